sme_driver: RTL
===============

SME_DRIVER -- requirements
Module: sme_driver

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 255, max cycles waited in WAIT for matcher valid.
REQ-002 SHALL have one clock and an asynchronous active-low reset, ports as listed below.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 wr_en  input  1  host write strobe into character buffers.
REQ-006 wr_pat  input  1  write target: 0 = string buffer (32 x 8), 1 = pattern buffer (8 x 8).
REQ-007 wr_addr  input  5  buffer index; pattern uses bits [2:0].
REQ-008 wr_data  input  8  character to store.
REQ-009 start  input  1  one-cycle job request.
REQ-010 keep_str  input  1  with start: skip string transfer and reuse matcher's held string.
REQ-011 str_len  input  6  string length 1..32, sampled on accepted start.
REQ-012 pat_len  input  4  pattern length 1..8, sampled on accepted start.
REQ-013 chardata  output  8  character to matcher.
REQ-014 isstring  output  1  chardata is a string character.
REQ-015 ispattern  output  1  chardata is a pattern character.
REQ-016 valid, match  input  1 each  matcher result strobe and result.
REQ-017 match_index  input  5  matcher result position.
REQ-018 busy  output  1  high from accepted start until the DONE cycle inclusive.
REQ-019 done  output  1  one-cycle job-complete pulse.
REQ-020 res_match, res_timeout  output  1 each  captured match; job ended without valid.
REQ-021 res_index  output  5  captured match_index.
REQ-022 err  output  1  one-cycle pulse on rejected start.

Function
REQ-023 States SHALL be IDLE, SEND_STR, SEND_PAT, WAIT, DONE; all outputs registered.
REQ-024 In IDLE, start with pat_len in 1..8 and (keep_str=1 or str_len in 1..32) SHALL be accepted: next state SEND_PAT if keep_str=1, else SEND_STR.
REQ-025 Any other start in IDLE SHALL pulse err the next cycle and remain IDLE; start outside IDLE SHALL be ignored.
REQ-026 SEND_STR SHALL drive isstring=1, chardata=string[k] for k=0..str_len-1 on consecutive cycles, first character the cycle after start.
REQ-027 SEND_PAT SHALL follow with no gap: ispattern=1, chardata=pattern[k], k=0..pat_len-1.
REQ-028 isstring and ispattern SHALL never be high together; outside send states both low and chardata=0.
REQ-029 WAIT SHALL count cycles from 0; on valid=1 capture match/match_index into res_match/res_index, res_timeout=0, go DONE.
REQ-030 If count reaches TIMEOUT_CYC without valid, SHALL go DONE with res_timeout=1, res_match=0, res_index=0.
REQ-031 valid arriving outside WAIT SHALL be ignored.
REQ-032 DONE SHALL last exactly one cycle with done=1, then IDLE; res_* hold until next DONE.
REQ-033 Buffer writes SHALL be accepted only when busy=0; wr_en during busy ignored; write and start in same IDLE cycle: write takes effect before transfer.
REQ-034 Index counter 6 bits; string index wraps never (bounded by str_len); out-of-range wr_addr for pattern uses low 3 bits.

Reset
REQ-035 Reset low SHALL force IDLE, all outputs 0, counters 0, buffers 0, asynchronously, including mid-transfer; isstring/ispattern drop immediately.

Structure
REQ-036 Package sme_pkg SHALL hold state encoding, MAX_STR=32, MAX_PAT=8, and pattern character constants (^ 8'h5E, $ 8'h24, * 8'h2A, . 8'h2E).
REQ-037 Buffers SHALL be one sub-module sme_char_buf (string + pattern arrays, write port, combinational read by index).

Verification
REQ-038 String "abc", pattern "bc" -> isstring 3 cycles then ispattern 2 cycles; model valid=1 match=1 index=1 -> done pulse, res_match=1, res_index=1.
REQ-039 keep_str=1, pattern "^a" -> no isstring cycle, ispattern 2 cycles immediately after start.
REQ-040 start with pat_len=0 -> err pulse, busy stays 0, no chardata activity.
REQ-041 No valid returned, TIMEOUT_CYC=255 -> done 255 cycles after WAIT entry, res_timeout=1.
REQ-042 reset asserted during SEND_STR k=10 -> outputs 0 immediately; after release, new start sends from index 0.
REQ-043 wr_en during busy overwriting string[0] -> next job still sends original character.

Source files
------------

// File: rtl/sme_pkg.sv
// sme_pkg: shared types and constants for the string-matching-engine driver.
//   state_e      : driver FSM state encoding
//   MAX_STR      : string buffer depth (characters)
//   MAX_PAT      : pattern buffer depth (characters)
//   CH_*         : pattern metacharacters understood by the matcher
//   start_ok()   : job-length legality check applied to a start request
package sme_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_SEND_STR = 3'd1,
      ST_SEND_PAT = 3'd2,
      ST_WAIT     = 3'd3,
      ST_DONE     = 3'd4
   } state_e;

   localparam logic [5:0] MAX_STR = 6'd32;
   localparam logic [3:0] MAX_PAT = 4'd8;

   localparam logic [7:0] CH_CARET  = 8'h5E;
   localparam logic [7:0] CH_DOLLAR = 8'h24;
   localparam logic [7:0] CH_STAR   = 8'h2A;
   localparam logic [7:0] CH_DOT    = 8'h2E;

   // A reused string needs no string length; a fresh one must fit the buffer.
   function automatic logic start_ok(input logic keep, input logic [5:0] slen,
                                     input logic [3:0] plen);
      logic pat_ok;
      logic str_ok;
      pat_ok = (plen >= 4'd1) && (plen <= MAX_PAT);
      str_ok = (slen >= 6'd1) && (slen <= MAX_STR);
      return pat_ok && (keep || str_ok);
   endfunction

endpackage

// File: rtl/sme_if.sv
// sme_if: host + matcher signal bundle of the driver.
//   host side   : wr_en/wr_pat/wr_addr/wr_data, start/keep_str/str_len/pat_len,
//                 busy/done/err, res_match/res_timeout/res_index
//   matcher side: chardata/isstring/ispattern out, valid/match/match_index in
//   modport slave  : the driver
//   modport master : the environment (host and matcher)
interface sme_if;
   logic       wr_en;
   logic       wr_pat;
   logic [4:0] wr_addr;
   logic [7:0] wr_data;
   logic       start;
   logic       keep_str;
   logic [5:0] str_len;
   logic [3:0] pat_len;
   logic [7:0] chardata;
   logic       isstring;
   logic       ispattern;
   logic       valid;
   logic       match;
   logic [4:0] match_index;
   logic       busy;
   logic       done;
   logic       res_match;
   logic       res_timeout;
   logic [4:0] res_index;
   logic       err;

   modport slave (
      input  wr_en, wr_pat, wr_addr, wr_data, start, keep_str, str_len, pat_len,
      input  valid, match, match_index,
      output chardata, isstring, ispattern, busy, done,
      output res_match, res_timeout, res_index, err
   );

   modport master (
      output wr_en, wr_pat, wr_addr, wr_data, start, keep_str, str_len, pat_len,
      output valid, match, match_index,
      input  chardata, isstring, ispattern, busy, done,
      input  res_match, res_timeout, res_index, err
   );
endinterface

// File: rtl/sme_char_buf.sv
// sme_char_buf: string (32 x 8) and pattern (8 x 8) character buffers.
//   clk, reset   : clock, asynchronous active-low reset (clears both arrays)
//   wr_*_i       : single write port; pattern uses wr_addr_i[2:0]
//   str_idx_i    : string read index  -> str_char_o (combinational)
//   pat_idx_i    : pattern read index -> pat_char_o (combinational)
// Reads forward a same-cycle write so a job started together with a write
// sees the new character.
module sme_char_buf
   import sme_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       wr_en_i,
   input  logic       wr_pat_i,
   input  logic [4:0] wr_addr_i,
   input  logic [7:0] wr_data_i,
   input  logic [4:0] str_idx_i,
   input  logic [2:0] pat_idx_i,
   output logic [7:0] str_char_o,
   output logic [7:0] pat_char_o
);

   logic [7:0] str_q [int'(MAX_STR)];
   logic [7:0] pat_q [int'(MAX_PAT)];

   // Buffer storage: cleared on reset, one character written per enabled cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < int'(MAX_STR); i++) str_q[i] <= 8'h00;
         for (int i = 0; i < int'(MAX_PAT); i++) pat_q[i] <= 8'h00;
      end else if (wr_en_i) begin
         if (wr_pat_i) pat_q[wr_addr_i[2:0]] <= wr_data_i;
         else          str_q[wr_addr_i]      <= wr_data_i;
      end
   end

   // Read ports with write-through forwarding.
   always_comb begin
      str_char_o = str_q[str_idx_i];
      pat_char_o = pat_q[pat_idx_i];
      if (wr_en_i && !wr_pat_i && (wr_addr_i == str_idx_i)) str_char_o = wr_data_i;
      else                                                 str_char_o = str_q[str_idx_i];
      if (wr_en_i && wr_pat_i && (wr_addr_i[2:0] == pat_idx_i)) pat_char_o = wr_data_i;
      else                                                     pat_char_o = pat_q[pat_idx_i];
   end

endmodule

// File: rtl/sme_driver.sv
// sme_driver: streams a buffered string and pattern to a matcher, then waits
// (bounded by TIMEOUT_CYC) for its result and reports it to the host.
//   clk, reset : clock, asynchronous active-low reset
//   bus        : sme_if.slave (host writes/start, matcher stream/result, status)
// Every output is a register loaded from the next-state decode, so the first
// character appears the cycle after an accepted start.
module sme_driver
   import sme_pkg::*;
#(
   parameter int TIMEOUT_CYC = 255
) (
   input logic  clk,
   input logic  reset,
   sme_if.slave bus
);

   localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

   state_e           state_q, state_d;
   logic [5:0]       idx_q, idx_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [5:0]       slen_q, slen_d;
   logic [3:0]       plen_q, plen_d;
   logic             res_match_q, res_match_d;
   logic             res_timeout_q, res_timeout_d;
   logic [4:0]       res_index_q, res_index_d;
   logic             err_q, err_d;
   logic [7:0]       chardata_q, chardata_d;
   logic             isstring_q, isstring_d;
   logic             ispattern_q, ispattern_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             wr_en_s;
   logic [7:0]       str_char_s;
   logic [7:0]       pat_char_s;

   // Host writes are only honoured while idle.
   assign wr_en_s = bus.wr_en && (state_q == ST_IDLE);

   sme_char_buf u_buf (
      .clk        (clk),
      .reset      (reset),
      .wr_en_i    (wr_en_s),
      .wr_pat_i   (bus.wr_pat),
      .wr_addr_i  (bus.wr_addr),
      .wr_data_i  (bus.wr_data),
      .str_idx_i  (idx_d[4:0]),
      .pat_idx_i  (idx_d[2:0]),
      .str_char_o (str_char_s),
      .pat_char_o (pat_char_s)
   );

   // State register and all registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= ST_IDLE;
         idx_q         <= 6'd0;
         cnt_q         <= '0;
         slen_q        <= 6'd0;
         plen_q        <= 4'd0;
         res_match_q   <= 1'b0;
         res_timeout_q <= 1'b0;
         res_index_q   <= 5'd0;
         err_q         <= 1'b0;
         chardata_q    <= 8'h00;
         isstring_q    <= 1'b0;
         ispattern_q   <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         cnt_q         <= cnt_d;
         slen_q        <= slen_d;
         plen_q        <= plen_d;
         res_match_q   <= res_match_d;
         res_timeout_q <= res_timeout_d;
         res_index_q   <= res_index_d;
         err_q         <= err_d;
         chardata_q    <= chardata_d;
         isstring_q    <= isstring_d;
         ispattern_q   <= ispattern_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
      end
   end

   // Next-state, index/timeout counters and result capture.
   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      cnt_d         = cnt_q;
      slen_d        = slen_q;
      plen_d        = plen_q;
      res_match_d   = res_match_q;
      res_timeout_d = res_timeout_q;
      res_index_d   = res_index_q;
      err_d         = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               if (start_ok(bus.keep_str, bus.str_len, bus.pat_len)) begin
                  slen_d  = bus.str_len;
                  plen_d  = bus.pat_len;
                  idx_d   = 6'd0;
                  state_d = bus.keep_str ? ST_SEND_PAT : ST_SEND_STR;
               end else begin
                  err_d = 1'b1;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SEND_STR: begin
            if (idx_q == (slen_q - 6'd1)) begin
               idx_d   = 6'd0;
               state_d = ST_SEND_PAT;
            end else begin
               idx_d = idx_q + 6'd1;
            end
         end
         ST_SEND_PAT: begin
            if (idx_q == ({2'b00, plen_q} - 6'd1)) begin
               idx_d   = 6'd0;
               cnt_d   = '0;
               state_d = ST_WAIT;
            end else begin
               idx_d = idx_q + 6'd1;
            end
         end
         ST_WAIT: begin
            // A result in the last counted cycle still beats the timeout.
            if (bus.valid) begin
               res_match_d   = bus.match;
               res_index_d   = bus.match_index;
               res_timeout_d = 1'b0;
               state_d       = ST_DONE;
            end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
               res_match_d   = 1'b0;
               res_index_d   = 5'd0;
               res_timeout_d = 1'b1;
               state_d       = ST_DONE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Output decode of the upcoming state, loaded into the output registers.
   always_comb begin
      isstring_d  = (state_d == ST_SEND_STR);
      ispattern_d = (state_d == ST_SEND_PAT);
      busy_d      = (state_d != ST_IDLE);
      done_d      = (state_d == ST_DONE);
      if (isstring_d)       chardata_d = str_char_s;
      else if (ispattern_d) chardata_d = pat_char_s;
      else                  chardata_d = 8'h00;
   end

   assign bus.chardata    = chardata_q;
   assign bus.isstring    = isstring_q;
   assign bus.ispattern   = ispattern_q;
   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.err         = err_q;
   assign bus.res_match   = res_match_q;
   assign bus.res_timeout = res_timeout_q;
   assign bus.res_index   = res_index_q;

endmodule
